// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// instruction classes, opcode/funct constants and alu_control bit indices.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBeq,
    ClsBne,
    ClsJump,
    ClsInvalid
  } inst_cls_e;

  // One-hot alu_control bit positions
  localparam int unsigned AluWidth = 13;
  localparam int unsigned AluDiv   = 12;
  localparam int unsigned AluAdd   = 11;
  localparam int unsigned AluSub   = 10;
  localparam int unsigned AluSlt   = 9;
  localparam int unsigned AluSltu  = 8;
  localparam int unsigned AluAnd   = 7;
  localparam int unsigned AluNor   = 6;
  localparam int unsigned AluOr    = 5;
  localparam int unsigned AluXor   = 4;
  localparam int unsigned AluSll   = 3;
  localparam int unsigned AluSrl   = 2;
  localparam int unsigned AluSra   = 1;
  localparam int unsigned AluLui   = 0;

  localparam logic [1:0] PcSeq    = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnDivu = 6'h1B;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

endpackage

// File: rtl/inst_decode.sv
// Combinational instruction decoder.
// Ports: ir_i (latched instruction) -> alu_ctrl_o (one-hot ALU op), src1_shamt_o,
// src2_imm_o, imm_zext_o, dest_rt_o, ovf_chk_o (ADD/SUB/ADDI trap on overflow),
// cls_o (instruction class driving the FSM).
module inst_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0]         ir_i,
  output logic [AluWidth-1:0] alu_ctrl_o,
  output logic                src1_shamt_o,
  output logic                src2_imm_o,
  output logic                imm_zext_o,
  output logic                dest_rt_o,
  output logic                ovf_chk_o,
  output inst_cls_e           cls_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_ir;

  assign op        = ir_i[31:26];
  assign funct     = ir_i[5:0];
  assign unused_ir = ^ir_i[25:6];

  always_comb begin
    alu_ctrl_o   = '0;
    src1_shamt_o = 1'b0;
    src2_imm_o   = 1'b0;
    imm_zext_o   = 1'b0;
    dest_rt_o    = 1'b0;
    ovf_chk_o    = 1'b0;
    cls_o        = ClsAlu;
    case (op)
      OpSpecial: begin
        case (funct)
          FnSll:  begin alu_ctrl_o[AluSll] = 1'b1; src1_shamt_o = 1'b1; end
          FnSrl:  begin alu_ctrl_o[AluSrl] = 1'b1; src1_shamt_o = 1'b1; end
          FnSra:  begin alu_ctrl_o[AluSra] = 1'b1; src1_shamt_o = 1'b1; end
          FnSllv: alu_ctrl_o[AluSll] = 1'b1;
          FnSrlv: alu_ctrl_o[AluSrl] = 1'b1;
          FnSrav: alu_ctrl_o[AluSra] = 1'b1;
          FnDivu: alu_ctrl_o[AluDiv] = 1'b1;
          FnAdd:  begin alu_ctrl_o[AluAdd] = 1'b1; ovf_chk_o = 1'b1; end
          FnAddu: alu_ctrl_o[AluAdd] = 1'b1;
          FnSub:  begin alu_ctrl_o[AluSub] = 1'b1; ovf_chk_o = 1'b1; end
          FnSubu: alu_ctrl_o[AluSub] = 1'b1;
          FnAnd:  alu_ctrl_o[AluAnd] = 1'b1;
          FnOr:   alu_ctrl_o[AluOr]  = 1'b1;
          FnXor:  alu_ctrl_o[AluXor] = 1'b1;
          FnNor:  alu_ctrl_o[AluNor] = 1'b1;
          FnSlt:  alu_ctrl_o[AluSlt] = 1'b1;
          FnSltu: alu_ctrl_o[AluSltu] = 1'b1;
          default: cls_o = ClsInvalid;
        endcase
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
        src2_imm_o = 1'b1;
        dest_rt_o  = 1'b1;
        case (op)
          OpAddi:  begin alu_ctrl_o[AluAdd] = 1'b1; ovf_chk_o = 1'b1; end
          OpAddiu: alu_ctrl_o[AluAdd]  = 1'b1;
          OpSlti:  alu_ctrl_o[AluSlt]  = 1'b1;
          OpSltiu: alu_ctrl_o[AluSltu] = 1'b1;
          OpAndi:  begin alu_ctrl_o[AluAnd] = 1'b1; imm_zext_o = 1'b1; end
          OpOri:   begin alu_ctrl_o[AluOr]  = 1'b1; imm_zext_o = 1'b1; end
          OpXori:  begin alu_ctrl_o[AluXor] = 1'b1; imm_zext_o = 1'b1; end
          default: alu_ctrl_o[AluLui] = 1'b1;
        endcase
      end
      OpLw: begin
        alu_ctrl_o[AluAdd] = 1'b1;
        src2_imm_o         = 1'b1;
        dest_rt_o          = 1'b1;
        cls_o              = ClsLoad;
      end
      OpSw: begin
        alu_ctrl_o[AluAdd] = 1'b1;
        src2_imm_o         = 1'b1;
        cls_o              = ClsStore;
      end
      OpBeq:   cls_o = ClsBeq;
      OpBne:   cls_o = ClsBne;
      OpJ:     cls_o = ClsJump;
      default: cls_o = ClsInvalid;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM (IF, ID, EX, MEM, WB).
// Inputs: clk, rst (sync, active-high), inst_rdata/inst_ready (ROM), data_ready (DMEM),
// rs_eq_rt and alu_overflow (sampled in EX).
// Outputs: alu_control (one-hot, EX only), fetch/PC strobes, datapath selects,
// memory and register-write strobes, exc/invalid pulses, current state.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_rdata,
  input  logic                inst_ready,
  input  logic                data_ready,
  input  logic                rs_eq_rt,
  input  logic                alu_overflow,
  output logic [AluWidth-1:0] alu_control,
  output logic                inst_req,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                src1_sel,
  output logic                src2_sel,
  output logic                imm_zext,
  output logic                mem_req,
  output logic                mem_we,
  output logic                reg_we,
  output logic                wb_sel,
  output logic                dest_sel,
  output logic                exc,
  output logic                invalid,
  output logic [2:0]          state
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        ovf_q, ovf_d;

  logic [AluWidth-1:0] dec_alu;
  logic                dec_src1, dec_src2, dec_zext, dec_dest_rt, dec_ovf_chk;
  inst_cls_e           dec_cls;

  inst_decode u_inst_decode (
    .ir_i         (ir_q),
    .alu_ctrl_o   (dec_alu),
    .src1_shamt_o (dec_src1),
    .src2_imm_o   (dec_src2),
    .imm_zext_o   (dec_zext),
    .dest_rt_o    (dec_dest_rt),
    .ovf_chk_o    (dec_ovf_chk),
    .cls_o        (dec_cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIf;
      ir_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ovf_d       = ovf_q;
    alu_control = '0;
    inst_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PcSeq;
    src1_sel    = 1'b0;
    src2_sel    = 1'b0;
    imm_zext    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    dest_sel    = 1'b0;
    exc         = 1'b0;
    invalid     = 1'b0;
    unique case (state_q)
      StIf: begin
        inst_req = 1'b1;
        if (inst_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          ir_d    = inst_rdata;
          state_d = StId;
        end
      end
      StId: begin
        if (dec_cls == ClsInvalid) begin
          invalid = 1'b1;
          state_d = StIf;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        alu_control = dec_alu;
        src1_sel    = dec_src1;
        src2_sel    = dec_src2;
        imm_zext    = dec_zext;
        // Overflow only matters for trapping ops; others clear the latch here
        ovf_d       = dec_ovf_chk & alu_overflow;
        case (dec_cls)
          ClsAlu:             state_d = StWb;
          ClsLoad, ClsStore:  state_d = StMem;
          ClsBeq, ClsBne: begin
            if ((dec_cls == ClsBeq) == rs_eq_rt) begin
              pc_we  = 1'b1;
              pc_sel = PcBranch;
            end
            state_d = StIf;
          end
          ClsJump: begin
            pc_we   = 1'b1;
            pc_sel  = PcJump;
            state_d = StIf;
          end
          default: state_d = StIf;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = (dec_cls == ClsStore);
        if (data_ready) begin
          state_d = (dec_cls == ClsStore) ? StIf : StWb;
        end
      end
      StWb: begin
        reg_we   = ~ovf_q;
        exc      = ovf_q;
        wb_sel   = (dec_cls == ClsLoad);
        dest_sel = dec_dest_rt;
        state_d  = StIf;
      end
      default: state_d = StIf;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: inputs driven and outputs sampled just
// after the falling edge, state advances on the rising edge.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_rdata;
  logic        inst_ready, data_ready, rs_eq_rt, alu_overflow;
  logic [12:0] alu_control;
  logic        inst_req, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic        src1_sel, src2_sel, imm_zext, mem_req, mem_we, reg_we, wb_sel, dest_sel;
  logic        exc, invalid;
  logic [2:0]  state;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  localparam logic [2:0] SIf = 3'd0, SId = 3'd1, SEx = 3'd2, SMem = 3'd3, SWb = 3'd4;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst_rdata   (inst_rdata),
    .inst_ready   (inst_ready),
    .data_ready   (data_ready),
    .rs_eq_rt     (rs_eq_rt),
    .alu_overflow (alu_overflow),
    .alu_control  (alu_control),
    .inst_req     (inst_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .src1_sel     (src1_sel),
    .src2_sel     (src2_sel),
    .imm_zext     (imm_zext),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .dest_sel     (dest_sel),
    .exc          (exc),
    .invalid      (invalid),
    .state        (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Strobes other than inst_req/state, packed for all-zero checks
  function automatic logic [26:0] strobes();
    return {alu_control, ir_we, pc_we, pc_sel, src1_sel, src2_sel, imm_zext,
            mem_req, mem_we, reg_we, wb_sel, dest_sel, exc, invalid};
  endfunction

  // Called in IF; fetches ins and leaves the DUT in EX
  task automatic fetch(input string tag, input logic [31:0] ins);
    inst_rdata = ins;
    inst_ready = 1'b1;
    #1;
    check_eq({tag, "_if_state"}, 32'(state), 32'(SIf));
    check_eq({tag, "_if_irwe"}, 32'(ir_we), 32'd1);
    check_eq({tag, "_if_pcwe"}, 32'(pc_we & (pc_sel == 2'd0)), 32'd1);
    nxt();
    check_eq({tag, "_id_state"}, 32'(state), 32'(SId));
    check_eq({tag, "_id_strobes"}, 32'(strobes()), 32'd0);
    nxt();
    check_eq({tag, "_ex_state"}, 32'(state), 32'(SEx));
  endtask

  initial begin
    rst = 1'b1; inst_rdata = '0; inst_ready = 1'b0; data_ready = 1'b1;
    rs_eq_rt = 1'b0; alu_overflow = 1'b0;
    nxt();
    nxt();
    check_eq("rst_state", 32'(state), 32'(SIf));
    check_eq("rst_inst_req", 32'(inst_req), 32'd1);
    check_eq("rst_strobes", 32'(strobes()), 32'd0);
    rst = 1'b0;

    // ADDU r3,r1,r2
    fetch("addu", 32'h0022_1821);
    check_eq("addu_ex_alu", 32'(alu_control), 32'h0800);
    check_eq("addu_ex_regwe", 32'(reg_we), 32'd0);
    nxt();
    check_eq("addu_wb_state", 32'(state), 32'(SWb));
    check_eq("addu_wb_regwe", 32'(reg_we), 32'd1);
    check_eq("addu_wb_sel", 32'({wb_sel, dest_sel}), 32'd0);
    nxt();
    check_eq("addu_done_state", 32'(state), 32'(SIf));
    check_eq("addu_done_regwe", 32'(reg_we), 32'd0);

    // LW with data_ready low for 3 cycles
    fetch("lw", 32'h8C22_0004);
    check_eq("lw_ex_alu", 32'(alu_control), 32'h0800);
    check_eq("lw_ex_src2", 32'(src2_sel), 32'd1);
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      check_eq("lw_mem_wait_state", 32'(state), 32'(SMem));
      check_eq("lw_mem_wait_req", 32'({mem_req, mem_we}), 32'b10);
    end
    nxt();
    data_ready = 1'b1;
    #1;
    check_eq("lw_mem_last_state", 32'(state), 32'(SMem));
    check_eq("lw_mem_last_we", 32'(mem_we), 32'd0);
    nxt();
    check_eq("lw_wb_state", 32'(state), 32'(SWb));
    check_eq("lw_wb_flags", 32'({reg_we, wb_sel, dest_sel}), 32'b111);
    nxt();
    check_eq("lw_done_state", 32'(state), 32'(SIf));

    // BEQ taken
    rs_eq_rt = 1'b1;
    fetch("beq_t", 32'h1022_0003);
    check_eq("beq_t_pc", 32'({pc_we, pc_sel}), 32'b101);
    check_eq("beq_t_alu", 32'(alu_control), 32'd0);
    nxt();
    check_eq("beq_t_next", 32'(state), 32'(SIf));

    // BEQ not taken
    rs_eq_rt = 1'b0;
    fetch("beq_n", 32'h1022_0003);
    check_eq("beq_n_pcwe", 32'(pc_we), 32'd0);
    check_eq("beq_n_alu", 32'(alu_control), 32'd0);
    nxt();
    check_eq("beq_n_next", 32'(state), 32'(SIf));

    // ADD with overflow
    fetch("add_ovf", 32'h0022_1820);
    alu_overflow = 1'b1;
    #1;
    check_eq("add_ovf_alu", 32'(alu_control), 32'h0800);
    nxt();
    alu_overflow = 1'b0;
    check_eq("add_ovf_wb_state", 32'(state), 32'(SWb));
    check_eq("add_ovf_wb", 32'({reg_we, exc}), 32'b01);
    nxt();
    check_eq("add_ovf_done", 32'({state, exc, reg_we}), 32'({SIf, 2'b00}));

    // Unrecognised opcode 0x3F
    inst_rdata = 32'hFC00_0000;
    inst_ready = 1'b1;
    nxt();
    check_eq("inv_id_state", 32'(state), 32'(SId));
    check_eq("inv_pulse", 32'(invalid), 32'd1);
    check_eq("inv_no_we", 32'({reg_we, mem_we, pc_we, ir_we}), 32'd0);
    nxt();
    check_eq("inv_back_if", 32'({state, invalid}), 32'({SIf, 1'b0}));

    // SLL uses shamt
    fetch("sll", 32'h0002_1080);
    check_eq("sll_ex", 32'({alu_control, src1_sel, src2_sel}), 32'({13'h0008, 2'b10}));
    nxt();
    nxt();

    // ORI: zero-extended immediate, writes rt
    fetch("ori", 32'h3422_0005);
    check_eq("ori_ex", 32'({alu_control, src2_sel, imm_zext}), 32'({13'h0020, 2'b11}));
    nxt();
    check_eq("ori_wb", 32'({state, reg_we, dest_sel}), 32'({SWb, 2'b11}));
    nxt();

    // DIVU
    fetch("divu", 32'h0022_001B);
    check_eq("divu_alu", 32'(alu_control), 32'h1000);
    nxt();
    nxt();

    // J
    fetch("j", 32'h0800_0010);
    check_eq("j_pc", 32'({pc_we, pc_sel, alu_control}), 32'({3'b110, 13'h0}));
    nxt();
    check_eq("j_next", 32'(state), 32'(SIf));

    // SW aborted by reset during MEM
    fetch("sw", 32'hAC22_0004);
    data_ready = 1'b0;
    nxt();
    check_eq("sw_mem", 32'({state, mem_req, mem_we}), 32'({SMem, 2'b11}));
    rst = 1'b1;
    inst_ready = 1'b0;
    nxt();
    check_eq("sw_rst_state", 32'(state), 32'(SIf));
    check_eq("sw_rst_we", 32'({mem_we, reg_we}), 32'd0);
    check_eq("sw_rst_strobes", 32'(strobes()), 32'd0);
    rst = 1'b0;
    data_ready = 1'b1;
    nxt();
    check_eq("sw_rst_idle", 32'({state, inst_req}), 32'({SIf, 1'b1}));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: inst_rdata  input  32  instruction ROM data, valid when inst_ready=1.
REQ-004 SHALL have port: inst_ready  input  1  ROM data valid this cycle.
REQ-005 SHALL have port: data_ready  input  1  data memory completed the requested access this cycle.
REQ-006 SHALL have port: rs_eq_rt  input  1  register-file compare result, sampled in EX.
REQ-007 SHALL have port: alu_overflow  input  1  ALU overflow flag, sampled in EX.
REQ-008 SHALL have port: alu_control  output  13  one-hot ALU op: [12]div [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui.
REQ-009 SHALL have ports: inst_req (1), ir_we (1), pc_we (1), pc_sel (2: 0 seq, 1 branch, 2 jump), src1_sel (1: 0 rs, 1 shamt), src2_sel (1: 0 rt, 1 imm), imm_zext (1), mem_req (1), mem_we (1), reg_we (1), wb_sel (1: 0 ALU, 1 mem), dest_sel (1: 0 rd, 1 rt), exc (1), invalid (1), state (3), all outputs.

Function
REQ-010 States: IF, ID, EX, MEM, WB; state output reflects current state.
REQ-011 IF: inst_req=1; hold in IF while inst_ready=0; on inst_ready=1 assert ir_we and pc_we (pc_sel=0) same cycle, next ID.
REQ-012 ID: decode latched IR; recognised instruction -> EX; unrecognised -> one-cycle invalid pulse, no writes, next IF.
REQ-013 EX: alu_control SHALL carry exactly one set bit for ALU-using instructions; zero in every other state and for BEQ/BNE/J.
REQ-014 Mapping: ADD/ADDU/ADDIU/LW/SW->add; SUB/SUBU->sub; SLT/SLTI->slt; SLTU/SLTIU->sltu; AND/ANDI->and; NOR->nor; OR/ORI->or; XOR/XORI->xor; SLL/SLLV->sll; SRL/SRLV->srl; SRA/SRAV->sra; LUI->lui; DIVU (funct 0x1B, writes quotient to rd)->div.
REQ-015 src1_sel=1 only for SLL/SRL/SRA; src2_sel=1 for all I-type ALU, LW, SW; imm_zext=1 for ANDI/ORI/XORI.
REQ-016 EX transitions: R-type/I-type ALU -> WB; LW/SW -> MEM; BEQ/BNE -> IF with pc_we=1,pc_sel=1 iff (BEQ&rs_eq_rt)|(BNE&~rs_eq_rt); J -> IF with pc_we=1,pc_sel=2.
REQ-017 MEM: mem_req=1, mem_we=1 for SW only; hold while data_ready=0; on data_ready SW -> IF, LW -> WB.
REQ-018 WB: reg_we=1 single cycle, wb_sel=1 for LW, dest_sel=1 for I-type/LW; next IF.
REQ-019 ADD/SUB/ADDI: alu_overflow latched at EX; in WB reg_we=0 and exc=1 for one cycle if latched set.
REQ-020 Latency with ready inputs high: R/I-type 4 cycles, LW 5, SW 4, branch/jump 3.
REQ-021 reg_we, mem_we, pc_we, ir_we, exc, invalid SHALL each be asserted at most one cycle per instruction (mem_we excepted while MEM waits).

Reset
REQ-022 rst=1 at any edge SHALL force state IF and clear IR, overflow latch; all outputs except inst_req and state SHALL be 0 on the cycle following reset.
REQ-023 Reset mid-MEM or mid-WB SHALL abort the instruction; no reg_we/mem_we asserted after the reset edge.

Structure
REQ-024 Package mc_ctrl_pkg SHALL hold state encoding, opcode/funct constants, and alu_control bit-index constants.
REQ-025 Combinational sub-module inst_decode SHALL map IR to alu_control, selects and instruction class; FSM stays in multi_cycle_ctrl.

Verification
REQ-026 ADDU r3,r1,r2 (0x00221821), ready high -> states IF,ID,EX,WB; alu_control=0x0800 in EX; reg_we=1 in WB only.
REQ-027 LW with data_ready low 3 cycles -> MEM held 4 cycles, mem_we=0, wb_sel=1 and reg_we=1 in following WB.
REQ-028 BEQ, rs_eq_rt=1 -> pc_we=1,pc_sel=1 in EX; with rs_eq_rt=0 -> pc_we=0, return to IF, alu_control=0.
REQ-029 ADD with alu_overflow=1 in EX -> WB reg_we=0, exc=1 one cycle.
REQ-030 Opcode 0x3F -> invalid=1 in ID, back to IF, no write strobes; rst pulsed in MEM of SW -> state IF next cycle, mem_we=0.
